ram_access_ctrl: RTL and testbench

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

---
 rtl/ram_access_pkg.sv | 16 +
 rtl/ram_access_ctrl_if.sv | 36 +++
 rtl/ram_access_ctrl.sv | 137 +++++++++++++
 tb/tb_ram_access_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_access_pkg.sv
// Shared types and constants for the RAM access controller.
package ram_access_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned RD_LAT_MAX = 3;
    localparam int unsigned RD_CNT_W   = $clog2(RD_LAT_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        CAPTURE = 2'd3
    } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request, RAM-side and result signals of ram_access_ctrl.
// master = requester side, slave = controller side.
interface ram_access_ctrl_if
    import ram_access_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              wr_done;
    logic              verify_err;

    modport master (
        output req_valid, req_write, req_addr, req_data, ram_q,
        input  req_ready, ram_address, ram_data, ram_wren,
        input  rd_valid, rd_data, wr_done, verify_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, ram_q,
        output req_ready, ram_address, ram_data, ram_wren,
        output rd_valid, rd_data, wr_done, verify_err
    );

endinterface

// File: rtl/ram_access_ctrl.sv
// Single-port RAM access controller: one read or write per request, fixed read latency.
// Optional write readback verify enabled by defining RAM_ACCESS_READBACK_EN.
module ram_access_ctrl
    import ram_access_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    ram_access_ctrl_if.slave   bus
);

    localparam logic [RD_CNT_W-1:0] CNT_LOAD = RD_CNT_W'(RD_LAT - 1);

    state_e              state_q, state_d;
    logic [RD_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                ready_q, ready_d;
    logic                wren_q, wren_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_done_q, wr_done_d;
    logic                accept_c;
`ifdef RAM_ACCESS_READBACK_EN
    logic                is_wr_q, is_wr_d;
    logic                verr_q, verr_d;
`endif

    // Next-state, latched request and pulse generation
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;
`ifdef RAM_ACCESS_READBACK_EN
        is_wr_d    = is_wr_q;
        verr_d     = verr_q;
`endif
        accept_c   = (state_q == IDLE) && bus.req_valid;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_data;
                    cnt_d   = CNT_LOAD;
                    state_d = bus.req_write ? WRITE : RD_WAIT;
`ifdef RAM_ACCESS_READBACK_EN
                    is_wr_d = bus.req_write;
                    if (bus.req_write) verr_d = 1'b0;
`endif
                end
            end
            WRITE: begin
`ifdef RAM_ACCESS_READBACK_EN
                // Read the just-written word back at the same address
                cnt_d   = CNT_LOAD;
                state_d = RD_WAIT;
`else
                wr_done_d = 1'b1;
                state_d   = IDLE;
`endif
            end
            RD_WAIT: begin
                if (cnt_q == '0) state_d = CAPTURE;
                else             cnt_d   = cnt_q - RD_CNT_W'(1);
            end
            CAPTURE: begin
                rd_data_d  = bus.ram_q;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
`ifdef RAM_ACCESS_READBACK_EN
                if (is_wr_q) begin
                    wr_done_d = 1'b1;
                    if (bus.ram_q != wdata_q) verr_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
        wren_d  = (state_d == WRITE);
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            ready_q    <= 1'b1;
            wren_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
`ifdef RAM_ACCESS_READBACK_EN
            is_wr_q    <= 1'b0;
            verr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            ready_q    <= ready_d;
            wren_q     <= wren_d;
            rd_valid_q <= rd_valid_d;
            wr_done_q  <= wr_done_d;
`ifdef RAM_ACCESS_READBACK_EN
            is_wr_q    <= is_wr_d;
            verr_q     <= verr_d;
`endif
        end
    end

    assign bus.req_ready   = ready_q;
    assign bus.ram_address = addr_q;
    assign bus.ram_data    = wdata_q;
    assign bus.ram_wren    = wren_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.wr_done     = wr_done_q;
`ifdef RAM_ACCESS_READBACK_EN
    assign bus.verify_err  = verr_q;
`else
    assign bus.verify_err  = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: three instances (RD_LAT 1..3), each with a behavioural RAM,
// checked against a per-instance memory array and latency arithmetic.
module tb_ram_access_ctrl;
    import ram_access_pkg::*;

    localparam int unsigned AW    = ADDR_W_DEF;
    localparam int unsigned DW    = DATA_W_DEF;
    localparam int unsigned NI    = 3;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid [NI];
    logic          req_write [NI];
    logic [AW-1:0] req_addr  [NI];
    logic [DW-1:0] req_data  [NI];
    logic          rdy [NI], wren [NI], rdv [NI], wrd [NI], verr [NI];
    logic [AW-1:0] raddr [NI];
    logic [DW-1:0] rwdat [NI], rdat [NI];
    logic [DW-1:0] stuck_mask;

    logic [DW-1:0] ref_mem [NI][DEPTH];
    logic [DW-1:0] exp_rd  [NI];
    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int unsigned LAT = g + 1;
        ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW-1:0] mem  [DEPTH];
        logic [DW-1:0] pipe [LAT];

        assign bus.req_valid = req_valid[g];
        assign bus.req_write = req_write[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_data  = req_data[g];
        assign bus.ram_q     = pipe[LAT-1];
        assign rdy[g]   = bus.req_ready;
        assign wren[g]  = bus.ram_wren;
        assign rdv[g]   = bus.rd_valid;
        assign wrd[g]   = bus.wr_done;
        assign verr[g]  = bus.verify_err;
        assign raddr[g] = bus.ram_address;
        assign rwdat[g] = bus.ram_data;
        assign rdat[g]  = bus.rd_data;

        ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
            .CLOCK_50 (clk),
            .RESET_N  (rst_n),
            .bus      (bus.slave)
        );

        initial for (int k = 0; k < int'(DEPTH); k++) mem[k] = '0;

        // RAM: read-before-write, q valid LAT cycles after the address is sampled
        always @(posedge clk) begin
            pipe[0] <= mem[bus.ram_address];
            for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
            if (bus.ram_wren) mem[bus.ram_address] = bus.ram_data & ~stuck_mask;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until it is taken; returns sampled just after the accept edge
    task automatic accept(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic was, ok;
        ok = 1'b0;
        req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i] = a; req_data[i] = d;
        for (int n = 0; n < 50; n++) begin
            was = rdy[i];
            tick();
            if (was) begin ok = 1'b1; break; end
        end
        req_valid[i] = 1'b0;
        req_write[i] = 1'($urandom);
        req_addr[i]  = AW'($urandom);
        req_data[i]  = DW'($urandom);
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic do_read(input int i, input logic [AW-1:0] a);
        int cyc, nwren;
        nwren = 0;
        accept(i, 1'b0, a, DW'($urandom));
        cyc = 1;
        while (!rdv[i] && cyc < 20) begin
            if (wren[i]) nwren++;
            tick();
            cyc++;
        end
        exp_rd[i] = ref_mem[i][a];
        chk("rd_latency", 32'(cyc), 32'(i + 1 + 2));
        chk("rd_data", 32'(rdat[i]), 32'(exp_rd[i]));
        chk("rd_no_wren", 32'(nwren), 32'd0);
        tick();
        chk("rd_valid_pulse", 32'(rdv[i]), 32'd0);
    endtask

    task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] stored;
        int cyc;
        stored = d & ~stuck_mask;
        accept(i, 1'b1, a, d);
        chk("wr_wren", 32'(wren[i]), 32'd1);
        chk("wr_addr", 32'(raddr[i]), 32'(a));
        chk("wr_data", 32'(rwdat[i]), 32'(d));
        chk("wr_verr_clear", 32'(verr[i]), 32'd0);
        ref_mem[i][a] = stored;
`ifdef RAM_ACCESS_READBACK_EN
        cyc = 1;
        while (!wrd[i] && cyc < 20) begin
            tick();
            cyc++;
            if (cyc == 2) chk("wr_wren_once", 32'(wren[i]), 32'd0);
        end
        exp_rd[i] = stored;
        chk("rb_latency", 32'(cyc), 32'(i + 1 + 3));
        chk("rb_rd_valid", 32'(rdv[i]), 32'd1);
        chk("rb_rd_data", 32'(rdat[i]), 32'(stored));
        chk("rb_verify_err", 32'(verr[i]), 32'(stored != d));
`else
        cyc = 1;
        tick();
        chk("wr_wren_once", 32'(wren[i]), 32'd0);
        chk("wr_done", 32'(wrd[i]), 32'd1);
        chk("wr_rd_data_kept", 32'(rdat[i]), 32'(exp_rd[i]));
        chk("wr_verify_tied", 32'(verr[i]), 32'd0);
`endif
        tick();
        chk("wr_done_pulse", 32'(wrd[i]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrdy, nrdv;
        logic [AW-1:0] a;
        stuck_mask = '0;
        for (int i = 0; i < int'(NI); i++) begin
            req_valid[i] = 1'b0; req_write[i] = 1'b0; req_addr[i] = '0; req_data[i] = '0;
            exp_rd[i] = '0;
            for (int k = 0; k < int'(DEPTH); k++) ref_mem[i][k] = '0;
        end

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < int'(NI); i++) begin
            chk("rst_rd_data", 32'(rdat[i]), 32'd0);
            chk("rst_wren", 32'(wren[i]), 32'd0);
            chk("rst_outputs", 32'({rdv[i], wrd[i], verr[i]}), 32'd0);
            chk("rst_addr", 32'(raddr[i]), 32'd0);
        end
        rst_n = 1'b1;
        chk("rst_ready", 32'(rdy[0]), 32'd1);

        // Basic write/read-back, then both address extremes
        do_write(0, 5'h03, 8'hA5);
        do_read(0, 5'h03);
        do_write(0, 5'h1F, 8'h3C);
        do_write(0, 5'h00, 8'hC3);
        do_read(0, 5'h1F);
        do_read(0, 5'h00);

        // Back-to-back reads with req_valid held: one accept per ready cycle
        do_write(1, 5'h1F, 8'h5A);
        nrdy = 0; nrdv = 0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 5'h1F;
        for (int n = 0; n < 3 * (2 + 2); n++) begin
            if (rdy[1]) nrdy++;
            tick();
            if (rdv[1]) begin
                nrdv++;
                chk("hold_rd_data", 32'(rdat[1]), 32'h5A);
            end
        end
        req_valid[1] = 1'b0;
        exp_rd[1] = 8'h5A;
        chk("hold_accepts", 32'(nrdy), 32'd3);
        chk("hold_pulses", 32'(nrdv), 32'd3);
        tick();
        chk("hold_no_extra", 32'(rdv[1]), 32'd0);

`ifdef RAM_ACCESS_READBACK_EN
        // Stuck-at-0 on bit 0 makes the readback disagree
        stuck_mask = 8'h01;
        do_write(0, 5'h03, 8'hA5);
        stuck_mask = '0;
        do_read(0, 5'h03);
        chk("verr_sticky", 32'(verr[0]), 32'd1);
        do_write(0, 5'h04, 8'h11);
        chk("verr_after_good", 32'(verr[0]), 32'd0);
`endif

        // Latency sweep plus randomized traffic on every instance
        for (int i = 0; i < int'(NI); i++) begin
            do_write(i, 5'h0A, DW'(8'h60 + i));
            do_read(i, 5'h0A);
            for (int n = 0; n < 16; n++) begin
                case ($urandom_range(0, 3))
                    0:       a = '0;
                    1:       a = '1;
                    default: a = AW'($urandom);
                endcase
                if ($urandom_range(0, 1) == 1) do_write(i, a, DW'($urandom));
                else                           do_read(i, a);
            end
        end

        // Reset while RD_LAT=3 instance is in RD_WAIT
        do_write(2, 5'h07, 8'h9E);
        accept(2, 1'b0, 5'h07, 8'h00);
        tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < int'(NI); i++) exp_rd[i] = '0;
        chk("mid_rst_wren", 32'(wren[2]), 32'd0);
        chk("mid_rst_rd_valid", 32'(rdv[2]), 32'd0);
        chk("mid_rst_rd_data", 32'(rdat[2]), 32'd0);
        chk("mid_rst_addr", 32'(raddr[2]), 32'd0);
        chk("mid_rst_data", 32'(rwdat[2]), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        chk("post_rst_ready", 32'(rdy[2]), 32'd1);
        nrdv = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (rdv[2] || wrd[2]) nrdv++;
        end
        chk("post_rst_no_pulse", 32'(nrdv), 32'd0);
        chk("post_rst_rd_data", 32'(rdat[2]), 32'd0);
        do_read(2, 5'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
